// File: rtl/cache_line_fill_ctrl.sv
// Miss-service controller: optional write-back of a dirty 4-word victim line,
// then refill of the missing line from fixed-latency backing memory.
module cache_line_fill_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              evict_dirty,
  input  logic [ADDR_W-1:0] evict_addr,
  input  logic [DATA_W-1:0] evict_rdata,
  output logic [1:0]        evict_idx,
  output logic              fill_we,
  output logic [1:0]        fill_idx,
  output logic [DATA_W-1:0] fill_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  output logic              mem_RE,
  input  logic [DATA_W-1:0] mem_RD
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_idx;
  logic [LAT_W-1:0]  r_lat;
  logic [ADDR_W-1:0] r_fill_base;
  logic [ADDR_W-1:0] r_wb_base;
  logic              w_lat_last;
  logic [ADDR_W-1:0] w_word_off;

  assign w_lat_last = (r_lat == LAT_LAST);
  assign w_word_off = {{(ADDR_W-4){1'b0}}, r_idx, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_lat       <= '0;
      r_fill_base <= '0;
      r_wb_base   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (miss_req) begin
            r_fill_base <= miss_addr & LINE_MASK;
            r_wb_base   <= evict_addr & LINE_MASK;
            r_idx       <= 2'd0;
            r_lat       <= '0;
          end
        end
        // The 2-bit index wraps to 0 after word 3, ready for the fill phase.
        S_WB: r_idx <= r_idx + 2'd1;
        S_FILL: begin
          if (w_lat_last) begin
            r_lat <= '0;
            r_idx <= r_idx + 2'd1;
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    evict_idx    = 2'd0;
    fill_we      = 1'b0;
    fill_idx     = 2'd0;
    fill_wdata   = '0;
    busy         = 1'b0;
    done         = 1'b0;
    mem_A        = '0;
    mem_WD       = '0;
    mem_WE       = 1'b0;
    mem_RE       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (miss_req) w_state_next = evict_dirty ? S_WB : S_FILL;
      end
      S_WB: begin
        busy      = 1'b1;
        mem_WE    = 1'b1;
        mem_A     = r_wb_base + w_word_off;
        evict_idx = r_idx;
        mem_WD    = evict_rdata;
        if (r_idx == 2'd3) w_state_next = S_FILL;
      end
      S_FILL: begin
        busy   = 1'b1;
        mem_RE = 1'b1;
        mem_A  = r_fill_base + w_word_off;
        // Read data is only trusted once the address has been held for the full latency.
        if (w_lat_last) begin
          fill_we    = 1'b1;
          fill_idx   = r_idx;
          fill_wdata = mem_RD;
          if (r_idx == 2'd3) w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Bench for cache_line_fill_ctrl: per-cycle expected traces built from the
// transaction rules, a backing-memory/cache model, and a MEM_LATENCY=1 instance.
module tb_cache_line_fill_ctrl;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          miss_req, evict_dirty;
  logic [AW-1:0] miss_addr, evict_addr;
  logic [DW-1:0] evict_rdata, fill_wdata, mem_WD, mem_RD;
  logic [1:0]    evict_idx, fill_idx;
  logic          fill_we, busy, done, mem_WE, mem_RE;
  logic [AW-1:0] mem_A;

  logic          miss_req1;
  logic [AW-1:0] miss_addr1;
  logic [DW-1:0] fill_wdata1, mem_WD1, mem_RD1;
  logic [1:0]    evict_idx1, fill_idx1;
  logic          fill_we1, busy1, done1, mem_WE1, mem_RE1;
  logic [AW-1:0] mem_A1;

  logic [DW-1:0] mem [0:511];
  logic [DW-1:0] victim [0:3];
  logic [DW-1:0] line_cap [0:3];

  int checks = 0;
  int errors = 0;
  int obs_done_cyc;
  logic [AW-1:0] obs_first_a;

  cache_line_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .evict_dirty(evict_dirty), .evict_addr(evict_addr), .evict_rdata(evict_rdata),
    .evict_idx(evict_idx), .fill_we(fill_we), .fill_idx(fill_idx),
    .fill_wdata(fill_wdata), .busy(busy), .done(done), .mem_A(mem_A),
    .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RE(mem_RE), .mem_RD(mem_RD));

  cache_line_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .miss_req(miss_req1), .miss_addr(miss_addr1),
    .evict_dirty(1'b0), .evict_addr(11'h000), .evict_rdata(32'h0),
    .evict_idx(evict_idx1), .fill_we(fill_we1), .fill_idx(fill_idx1),
    .fill_wdata(fill_wdata1), .busy(busy1), .done(done1), .mem_A(mem_A1),
    .mem_WD(mem_WD1), .mem_WE(mem_WE1), .mem_RE(mem_RE1), .mem_RD(mem_RD1));

  assign evict_rdata = victim[evict_idx];
  assign mem_RD      = mem[mem_A[10:2]];
  assign mem_RD1     = {16'hBEEF, 5'd0, mem_A1};

  always @(posedge clk) begin
    if (mem_WE) mem[mem_A[10:2]] = mem_WD;
    if (fill_we) line_cap[fill_idx] <= fill_wdata;
  end

  typedef struct {
    logic [AW-1:0] maddr;
    logic [AW-1:0] eaddr;
    logic          dirty;
    logic [AW-1:0] first_a;
    int            done_cyc;
  } vec_t;

  function automatic logic [83:0] pk(input logic b, input logic d, input logic we,
      input logic re, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic fwe,
      input logic [1:0] fidx, input logic [DW-1:0] fwd, input logic [1:0] eidx);
    return {b, d, we, re, a, wd, fwe, fidx, fwd, eidx};
  endfunction

  function automatic logic [83:0] act0();
    return pk(busy, done, mem_WE, mem_RE, mem_A, mem_WD, fill_we, fill_idx, fill_wdata, evict_idx);
  endfunction

  function automatic logic [83:0] act1();
    return pk(busy1, done1, mem_WE1, mem_RE1, mem_A1, mem_WD1, fill_we1, fill_idx1, fill_wdata1, evict_idx1);
  endfunction

  task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Starts at a sample point inside an IDLE cycle; ends at the sample point of
  // the IDLE cycle that follows done.
  task automatic run_txn(input logic [AW-1:0] maddr, input logic [AW-1:0] eaddr,
                         input logic dirty, input bit mutate);
    logic [83:0]   exp_q[$];
    logic [AW-1:0] fb, wb;
    logic [DW-1:0] fdata [4];
    bit            last;
    fb = maddr & 11'h7F0;
    wb = eaddr & 11'h7F0;
    for (int k = 0; k < 4; k++)
      fdata[k] = (dirty && wb == fb) ? victim[k] : mem[(int'(fb) >> 2) + k];
    if (dirty)
      for (int k = 0; k < 4; k++)
        exp_q.push_back(pk(1, 0, 1, 0, wb + AW'(4 * k), victim[k], 0, 2'd0, 32'h0, 2'(k)));
    for (int k = 0; k < 4; k++)
      for (int t = 0; t < LAT; t++) begin
        last = (t == LAT - 1);
        exp_q.push_back(pk(1, 0, 0, 1, fb + AW'(4 * k), 32'h0, last,
                           last ? 2'(k) : 2'd0, last ? fdata[k] : 32'h0, 2'd0));
      end
    exp_q.push_back(pk(1, 1, 0, 0, 11'h0, 32'h0, 0, 2'd0, 32'h0, 2'd0));

    miss_req = 1'b1; miss_addr = maddr; evict_addr = eaddr; evict_dirty = dirty;
    obs_done_cyc = 0;
    obs_first_a  = '0;
    @(posedge clk); #1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      check($sformatf("txn %h/%h/%0d cyc%0d", maddr, eaddr, dirty, c), act0(), exp_q[c-1]);
      if (c == 1) obs_first_a = mem_A;
      if (done && obs_done_cyc == 0) obs_done_cyc = c;
      if (mutate && c == 3) begin
        miss_addr   = AW'($urandom);
        evict_addr  = AW'($urandom);
        evict_dirty = ~dirty;
      end
      if (c == exp_q.size()) miss_req = 1'b0;
      else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    check("idle after done", act0(), 84'h0);
    for (int k = 0; k < 4; k++)
      check($sformatf("line word%0d", k), {52'h0, line_cap[k]}, {52'h0, fdata[k]});
    if (dirty)
      for (int k = 0; k < 4; k++)
        check($sformatf("wb word%0d", k), {52'h0, mem[(int'(wb) >> 2) + k]}, {52'h0, victim[k]});
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{11'h124, 11'h000, 1'b0, 11'h120, 4 * LAT + 1};
    vecs[1] = '{11'h040, 11'h204, 1'b1, 11'h200, 4 * LAT + 5};
    vecs[2] = '{11'h7FF, 11'h000, 1'b0, 11'h7F0, 4 * LAT + 1};
    vecs[3] = '{11'h00C, 11'h7F8, 1'b1, 11'h7F0, 4 * LAT + 5};

    rst = 1'b1;
    miss_req = 1'b0; miss_addr = '0; evict_addr = '0; evict_dirty = 1'b0;
    miss_req1 = 1'b0; miss_addr1 = '0;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    for (int k = 0; k < 4; k++) begin
      mem[72 + k] = 32'hA0 + k;
      victim[k]   = 32'hD0 + k;
      line_cap[k] = '0;
    end
    idle(2);
    check("reset dut", act0(), 84'h0);
    check("reset dut1", act1(), 84'h0);
    rst = 1'b0;
    idle(1);
    check("post-reset idle", act0(), 84'h0);

    foreach (vecs[v]) begin
      run_txn(vecs[v].maddr, vecs[v].eaddr, vecs[v].dirty, 1'b0);
      check($sformatf("vec%0d first mem_A", v), {73'h0, obs_first_a}, {73'h0, vecs[v].first_a});
      check($sformatf("vec%0d done cycle", v), 84'(obs_done_cyc), 84'(vecs[v].done_cyc));
    end

    // Inputs changed mid-transaction, then back-to-back acceptance.
    run_txn(11'h35A, 11'h1A0, 1'b0, 1'b1);
    run_txn(11'h2C4, 11'h3E8, 1'b1, 1'b1);
    run_txn(11'h2C4, 11'h2C0, 1'b1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 4; k++) victim[k] = $urandom;
      idle($urandom_range(0, 2));
      run_txn(AW'($urandom), AW'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset after word 1 has been written into the line.
    miss_req = 1'b1; miss_addr = 11'h300; evict_dirty = 1'b0;
    @(posedge clk); #1;
    begin
      bit found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        if (fill_we && fill_idx == 2'd1) found = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      check("word1 fill seen", {83'h0, found}, {83'h0, 1'b1});
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async reset outputs", act0(), 84'h0);
    miss_req = 1'b0;
    @(posedge clk); #1;
    check("held reset outputs", act0(), 84'h0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      idle(1);
      check($sformatf("no done after reset %0d", c), act0(), 84'h0);
    end
    run_txn(11'h100, 11'h000, 1'b0, 1'b0);
    check("restart first mem_A", {73'h0, obs_first_a}, {73'h0, 11'h100});

    // MEM_LATENCY=1 instance: one fill word per cycle.
    miss_req1 = 1'b1; miss_addr1 = 11'h010;
    @(posedge clk); #1;
    for (int c = 1; c <= 6; c++) begin
      logic [AW-1:0] a;
      bit f;
      f = (c <= 4);
      a = f ? AW'(11'h010 + 4 * (c - 1)) : 11'h000;
      check($sformatf("lat1 cyc%0d", c), act1(),
            pk(c <= 5, c == 5, 0, f, a, 32'h0, f, f ? 2'(c - 1) : 2'd0,
               f ? {16'hBEEF, 5'd0, a} : 32'h0, 2'd0));
      if (c == 5) miss_req1 = 1'b0;
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
